// File: rtl/fft_pkg.sv
// Shared definitions for the parametrised radix-2 FFT address generator.
// Contents:
//   state_t  - sequencer state encoding (IDLE, RUN, DRAIN, DONE)
//   rotl     - rotate-left of a value inside a field of given width
//   tw_mask  - twiddle mask with the top 'lvl' bits of 'width' set
//   legal ranges for LOG2N and BFLY_LAT
package fft_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int LOG2N_MIN    = 2;
    localparam int LOG2N_MAX    = 12;
    localparam int BFLY_LAT_MIN = 1;
    localparam int BFLY_LAT_MAX = 15;

    // amount must lie in 0..width-1; bits above width are cleared.
    function automatic logic [31:0] rotl(input logic [31:0] value, input int amount,
                                         input int width);
        logic [31:0] mask;
        mask = (32'd1 << width) - 32'd1;
        return ((value << amount) | (value >> (width - amount))) & mask;
    endfunction

    // lvl must lie in 0..width; lvl = 0 gives an all-zero mask.
    function automatic logic [31:0] tw_mask(input int lvl, input int width);
        logic [31:0] ones;
        ones = (32'd1 << lvl) - 32'd1;
        return ones << (width - lvl);
    endfunction

endpackage

// File: rtl/fft_wr_delay_line.sv
// Free-running shift line carrying {wr_en, wr_a_addr, wr_b_addr} from the
// read issue point to the write point of the butterfly datapath.
// Ports:
//   clk   - system clock
//   clr_n - asynchronous active-low clear of every stage
//   din   - WIDTH-bit word entering the line
//   dout  - din delayed by exactly DEPTH cycles
module fft_wr_delay_line #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            for (int k = 0; k < DEPTH; k++) stage[k] <= '0;
        end else begin
            stage[0] <= din;
            for (int k = 1; k < DEPTH; k++) stage[k] <= stage[k-1];
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/fft_addr_gen_param.sv
// In-place DIT radix-2 FFT address sequencer for N = 2^LOG2N points.
// For every butterfly (level i, index j) it issues read addresses
// rotl({j,0},i) / rotl({j,1},i), the twiddle address j & mask_i, and the
// matching write addresses BFLY_LAT cycles later. Levels are separated by a
// drain of BFLY_LAT+1 cycles so the last write of a level retires before
// the first read of the next one.
// Ports:
//   clk, clr_n          - clock, asynchronous active-low reset
//   start, inverse      - run request (IDLE only) and transform direction
//   stall               - holds off butterfly issue while high
//   busy, done          - run in progress / one-cycle completion pulse
//   rd_valid, rd_a_addr, rd_b_addr, tw_addr - registered read issue
//   tw_conj             - inverse latched at start
//   wr_en, wr_a_addr, wr_b_addr - delayed write side (addresses 0 when idle)
//   bank_sel            - read bank; writes target the other bank
//   level               - current level i
//
// state | meaning
// IDLE  | waiting for start
// RUN   | issuing butterflies of level i, one per unstalled cycle
// DRAIN | BFLY_LAT+1 cycles letting the level's writes retire
// DONE  | final level drained; done pulse follows
module fft_addr_gen_param
    import fft_pkg::*;
#(
    parameter int LOG2N    = 5,
    parameter int BFLY_LAT = 2
) (
    input  logic                     clk,
    input  logic                     clr_n,
    input  logic                     start,
    input  logic                     inverse,
    input  logic                     stall,
    output logic                     busy,
    output logic                     done,
    output logic                     rd_valid,
    output logic [LOG2N-1:0]         rd_a_addr,
    output logic [LOG2N-1:0]         rd_b_addr,
    output logic [LOG2N-2:0]         tw_addr,
    output logic                     tw_conj,
    output logic                     wr_en,
    output logic [LOG2N-1:0]         wr_a_addr,
    output logic [LOG2N-1:0]         wr_b_addr,
    output logic                     bank_sel,
    output logic [$clog2(LOG2N)-1:0] level
);

    localparam int LW   = $clog2(LOG2N);
    localparam int TW_W = LOG2N - 1;
    localparam int DW   = 1 + 2 * LOG2N;
    localparam logic [LW-1:0]   I_LAST = LW'(LOG2N - 1);
    localparam logic [TW_W-1:0] J_LAST = '1;

    if (LOG2N < LOG2N_MIN || LOG2N > LOG2N_MAX ||
        BFLY_LAT < BFLY_LAT_MIN || BFLY_LAT > BFLY_LAT_MAX) begin : g_bad_param
        $error("fft_addr_gen_param: LOG2N or BFLY_LAT outside legal range");
    end

    state_t            state, state_next;
    logic [LW-1:0]     i_cnt;
    logic [TW_W-1:0]   j_cnt;
    logic [3:0]        drain_cnt;
    logic              accept, issue, drain_exit;
    logic [LOG2N-1:0]  rd_a_next, rd_b_next, rd_a_gated, rd_b_gated;
    logic [TW_W-1:0]   tw_next;
    logic [DW-1:0]     dl_in, dl_out;

    assign level = i_cnt;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    // done is registered one cycle behind the DONE state so that it lines up
    // with the registered issue stream; a start seen while done is still
    // high belongs to the finished run and is refused.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        issue      = 1'b0;
        drain_exit = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && !done) begin
                    accept     = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!stall) begin
                    issue = 1'b1;
                    if (j_cnt == J_LAST) state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt == 4'd0) begin
                    drain_exit = 1'b1;
                    state_next = (i_cnt == I_LAST) ? ST_DONE : ST_RUN;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_a_next = LOG2N'(rotl(32'({j_cnt, 1'b0}), int'(i_cnt), LOG2N));
        rd_b_next = LOG2N'(rotl(32'({j_cnt, 1'b1}), int'(i_cnt), LOG2N));
        tw_next   = j_cnt & TW_W'(tw_mask(int'(i_cnt), TW_W));
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_valid  <= 1'b0;
            rd_a_addr <= '0;
            rd_b_addr <= '0;
            tw_addr   <= '0;
            tw_conj   <= 1'b0;
            bank_sel  <= 1'b0;
            i_cnt     <= '0;
            j_cnt     <= '0;
            drain_cnt <= '0;
        end else begin
            busy     <= (state != ST_IDLE);
            done     <= (state == ST_DONE);
            rd_valid <= issue;
            if (accept) begin
                tw_conj  <= inverse;
                bank_sel <= 1'b0;
                i_cnt    <= '0;
                j_cnt    <= '0;
            end
            if (issue) begin
                rd_a_addr <= rd_a_next;
                rd_b_addr <= rd_b_next;
                tw_addr   <= tw_next;
                j_cnt     <= j_cnt + 1'b1;
            end
            if (state == ST_RUN && state_next == ST_DRAIN)
                drain_cnt <= 4'(BFLY_LAT);
            else if (state == ST_DRAIN && drain_cnt != 4'd0)
                drain_cnt <= drain_cnt - 4'd1;
            if (drain_exit) begin
                bank_sel <= ~bank_sel;
                j_cnt    <= '0;
                if (i_cnt != I_LAST) i_cnt <= i_cnt + 1'b1;
            end
        end
    end

    // Addresses are zeroed on entry to the line so the write side never
    // shows stale addresses while wr_en is low.
    always_comb begin
        rd_a_gated = rd_valid ? rd_a_addr : '0;
        rd_b_gated = rd_valid ? rd_b_addr : '0;
        dl_in      = {rd_valid, rd_a_gated, rd_b_gated};
    end

    fft_wr_delay_line #(
        .WIDTH (DW),
        .DEPTH (BFLY_LAT)
    ) u_wr_delay (
        .clk   (clk),
        .clr_n (clr_n),
        .din   (dl_in),
        .dout  (dl_out)
    );

    assign {wr_en, wr_a_addr, wr_b_addr} = dl_out;

endmodule

// File: tb/tb_fft_addr_gen_param.sv
module tb_fft_addr_gen_param;

    localparam int L5 = 5, LAT5 = 2, L3 = 3, LAT3 = 1;

    logic clk = 1'b0;
    logic clr_n = 1'b0;
    logic start = 1'b0, inverse = 1'b0, stall = 1'b0;
    logic start3 = 1'b0, inverse3 = 1'b0, stall3 = 1'b0;

    logic       busy, done, rd_valid, tw_conj, wr_en, bank_sel;
    logic [4:0] rd_a, rd_b, wr_a, wr_b;
    logic [3:0] tw;
    logic [2:0] level;

    logic       busy3, done3, rd_valid3, tw_conj3, wr_en3, bank_sel3;
    logic [2:0] rd_a3, rd_b3, wr_a3, wr_b3;
    logic [1:0] tw3;
    logic [1:0] level3;

    always #5 clk = ~clk;

    fft_addr_gen_param #(.LOG2N(L5), .BFLY_LAT(LAT5)) dut (
        .clk(clk), .clr_n(clr_n), .start(start), .inverse(inverse), .stall(stall),
        .busy(busy), .done(done), .rd_valid(rd_valid), .rd_a_addr(rd_a), .rd_b_addr(rd_b),
        .tw_addr(tw), .tw_conj(tw_conj), .wr_en(wr_en), .wr_a_addr(wr_a), .wr_b_addr(wr_b),
        .bank_sel(bank_sel), .level(level)
    );

    fft_addr_gen_param #(.LOG2N(L3), .BFLY_LAT(LAT3)) dut3 (
        .clk(clk), .clr_n(clr_n), .start(start3), .inverse(inverse3), .stall(stall3),
        .busy(busy3), .done(done3), .rd_valid(rd_valid3), .rd_a_addr(rd_a3), .rd_b_addr(rd_b3),
        .tw_addr(tw3), .tw_conj(tw_conj3), .wr_en(wr_en3), .wr_a_addr(wr_a3), .wr_b_addr(wr_b3),
        .bank_sel(bank_sel3), .level(level3)
    );

    typedef struct {
        int lvl;
        int j;
        int a;
        int b;
        int tw;
    } rec_t;

    rec_t rd_q[$];
    rec_t wr_q[$];
    rec_t rd3_q[$];

    int   errors = 0;
    int   checks = 0;
    int   cyc = -100;
    int   rd_cnt, wr_cnt, done_cnt, done_cyc, last_wr_cyc, first_l1_rd, last_l0_wr;
    int   last_a, last_b, last_tw;
    int   rd3_cnt, done3_cnt, done3_cyc, last3_a, last3_b;
    logic exp_conj = 1'b0;
    logic h1 = 1'b0, h2 = 1'b0;

    // Reference butterfly addresses built bit by bit.
    function automatic rec_t model(input int L, input int lvl, input int j);
        rec_t r;
        int   va, vb;
        va = 2 * j;
        vb = 2 * j + 1;
        r.lvl = lvl; r.j = j; r.a = 0; r.b = 0; r.tw = 0;
        for (int b = 0; b < L; b++) begin
            if (((va >> b) & 1) == 1) r.a = r.a | (1 << ((b + lvl) % L));
            if (((vb >> b) & 1) == 1) r.b = r.b | (1 << ((b + lvl) % L));
        end
        for (int b = 0; b < L - 1; b++)
            if (b >= L - 1 - lvl && ((j >> b) & 1) == 1) r.tw = r.tw | (1 << b);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic mon5();
        rec_t r;
        if (rd_valid) begin
            if (rd_q.size() == 0) begin
                chk("rd_extra", 32'(rd_valid), 32'd0);
            end else begin
                r = rd_q.pop_front();
                chk("rd_a", 32'(rd_a), 32'(r.a));
                chk("rd_b", 32'(rd_b), 32'(r.b));
                chk("tw", 32'(tw), 32'(r.tw));
                chk("level", 32'(level), 32'(r.lvl));
                chk("bank_sel", 32'(bank_sel), 32'(r.lvl % 2));
                if (r.lvl == 0 && r.j == 3)
                    chk("spot_l0_j3", 32'({rd_a, rd_b, tw}), 32'({5'd6, 5'd7, 4'd0}));
                if (r.lvl == 1 && r.j == 3)
                    chk("spot_l1_j3", 32'({rd_a, rd_b, tw}), 32'({5'd12, 5'd14, 4'd0}));
                if (r.lvl == 4 && r.j == 3)
                    chk("spot_l4_j3", 32'({rd_a, rd_b, tw}), 32'({5'd3, 5'd19, 4'd3}));
                if (r.lvl == 1 && first_l1_rd < 0) first_l1_rd = cyc;
                last_a = r.a; last_b = r.b; last_tw = r.tw;
                rd_cnt++;
            end
        end else begin
            chk("rd_hold_a", 32'(rd_a), 32'(last_a));
            chk("rd_hold_b", 32'(rd_b), 32'(last_b));
            chk("tw_hold", 32'(tw), 32'(last_tw));
        end
        chk("wr_lag", 32'(wr_en), 32'(h2));
        h2 = h1;
        h1 = rd_valid;
        if (wr_en) begin
            if (wr_q.size() == 0) begin
                chk("wr_extra", 32'(wr_en), 32'd0);
            end else begin
                r = wr_q.pop_front();
                chk("wr_a", 32'(wr_a), 32'(r.a));
                chk("wr_b", 32'(wr_b), 32'(r.b));
                if (r.lvl == 0) last_l0_wr = cyc;
                wr_cnt++;
                last_wr_cyc = cyc;
            end
        end else begin
            chk("wr_zero", 32'({wr_a, wr_b}), 32'd0);
        end
        chk("tw_conj", 32'(tw_conj), 32'(exp_conj));
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            chk("busy_at_done", 32'(busy), 32'd1);
            chk("bank_final", 32'(bank_sel), 32'(L5 % 2));
        end
    endtask

    task automatic mon3();
        rec_t r;
        if (rd_valid3) begin
            if (rd3_q.size() == 0) begin
                chk("rd3_extra", 32'(rd_valid3), 32'd0);
            end else begin
                r = rd3_q.pop_front();
                chk("rd3_a", 32'(rd_a3), 32'(r.a));
                chk("rd3_b", 32'(rd_b3), 32'(r.b));
                chk("tw3", 32'(tw3), 32'(r.tw));
                if (r.lvl == 2 && r.j == 1)
                    chk("spot3_l2_j1", 32'({rd_a3, rd_b3, tw3}), 32'({3'd1, 3'd5, 2'd1}));
                last3_a = r.a; last3_b = r.b;
                rd3_cnt++;
            end
        end else begin
            chk("rd3_hold", 32'({rd_a3, rd_b3}), 32'({last3_a[2:0], last3_b[2:0]}));
        end
        if (done3) begin
            done3_cnt++;
            done3_cyc = cyc;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        mon5();
        mon3();
    endtask

    task automatic model_reset();
        rd_q.delete(); wr_q.delete(); rd3_q.delete();
        h1 = 1'b0; h2 = 1'b0;
        last_a = 0; last_b = 0; last_tw = 0; last3_a = 0; last3_b = 0;
        exp_conj = 1'b0;
        rd_cnt = 0; wr_cnt = 0; done_cnt = 0; done_cyc = -1;
        rd3_cnt = 0; done3_cnt = 0; done3_cyc = -1;
    endtask

    task automatic launch5(input logic inv);
        rd_q.delete(); wr_q.delete();
        for (int lv = 0; lv < L5; lv++)
            for (int jj = 0; jj < (1 << (L5 - 1)); jj++) begin
                rd_q.push_back(model(L5, lv, jj));
                wr_q.push_back(model(L5, lv, jj));
            end
        rd_cnt = 0; wr_cnt = 0; done_cnt = 0; done_cyc = -1;
        last_wr_cyc = -1; first_l1_rd = -1; last_l0_wr = -1;
        inverse  = inv;
        exp_conj = inv;
        start    = 1'b1;
        cyc      = -1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done5();
        for (int t = 0; t < 300 && done_cnt == 0; t++) tick();
    endtask

    initial begin
        model_reset();
        last_wr_cyc = -1; first_l1_rd = -1; last_l0_wr = -1;

        // Reset state
        clr_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ctrl", 32'({busy, done, rd_valid, tw_conj, wr_en, bank_sel, level}), 32'd0);
        chk("reset_addr", 32'({rd_a, rd_b, tw, wr_a, wr_b}), 32'd0);
        chk("reset_ctrl3", 32'({busy3, done3, rd_valid3, tw_conj3, wr_en3, bank_sel3, level3}), 32'd0);
        #2 clr_n = 1'b1;
        repeat (3) tick();

        // Plain run, LOG2N=5, BFLY_LAT=2
        launch5(1'b0);
        wait_done5();
        chk("A_done_seen", 32'(done_cnt), 32'd1);
        chk("A_done_cycle", 32'(done_cyc), 32'd96);
        chk("A_rd_count", 32'(rd_cnt), 32'd80);
        chk("A_wr_count", 32'(wr_cnt), 32'd80);
        chk("A_last_wr", 32'(last_wr_cyc), 32'd94);
        chk("A_first_l1_rd", 32'(first_l1_rd), 32'd20);
        chk("A_last_l0_wr", 32'(last_l0_wr), 32'd18);
        repeat (2) tick();
        chk("A_idle_busy", 32'(busy), 32'd0);
        chk("A_bank_hold", 32'(bank_sel), 32'd1);

        // Stall in level 2, stall in a drain, extra starts, inverse toggling
        launch5(1'b1);
        for (int t = 0; t < 300 && done_cnt == 0; t++) begin
            start   = (cyc == 10 || cyc == 60);
            inverse = (cyc % 2 == 0);
            stall   = (cyc >= 44 && cyc < 48) || (cyc >= 16 && cyc < 19);
            tick();
        end
        start = 1'b0; stall = 1'b0;
        chk("B_done_cycle", 32'(done_cyc), 32'd100);
        chk("B_rd_count", 32'(rd_cnt), 32'd80);
        chk("B_wr_count", 32'(wr_cnt), 32'd80);
        start   = 1'b1;
        inverse = 1'b0;
        tick();
        start = 1'b0;
        repeat (3) tick();
        chk("B_start_in_done", 32'(busy), 32'd0);
        chk("B_done_once", 32'(done_cnt), 32'd1);
        chk("B_no_rerun", 32'(rd_cnt), 32'd80);

        // Abort by reset at cycle 40
        launch5(1'b0);
        for (int t = 0; t < 100 && cyc < 40; t++) tick();
        clr_n = 1'b0;
        #1;
        model_reset();
        chk("C_abort_ctrl", 32'({busy, done, rd_valid, tw_conj, wr_en, bank_sel, level}), 32'd0);
        chk("C_abort_addr", 32'({rd_a, rd_b, tw, wr_a, wr_b}), 32'd0);
        repeat (3) tick();
        chk("C_no_done", 32'(done_cnt), 32'd0);
        #2 clr_n = 1'b1;
        repeat (2) tick();
        launch5(1'b0);
        wait_done5();
        chk("D_done_cycle", 32'(done_cyc), 32'd96);
        chk("D_rd_count", 32'(rd_cnt), 32'd80);
        chk("D_wr_count", 32'(wr_cnt), 32'd80);
        repeat (2) tick();

        // LOG2N=3, BFLY_LAT=1
        rd3_q.delete();
        for (int lv = 0; lv < L3; lv++)
            for (int jj = 0; jj < (1 << (L3 - 1)); jj++)
                rd3_q.push_back(model(L3, lv, jj));
        rd3_cnt = 0; done3_cnt = 0; done3_cyc = -1;
        start3 = 1'b1;
        cyc    = -1;
        tick();
        start3 = 1'b0;
        for (int t = 0; t < 100 && done3_cnt == 0; t++) tick();
        chk("E_done_cycle", 32'(done3_cyc), 32'd19);
        chk("E_rd_count", 32'(rd3_cnt), 32'd12);
        chk("E_bank_final", 32'(bank_sel3), 32'(L3 % 2));
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
